// File: rtl/downselect_mask_sequencer.sv
// downselect_mask_sequencer
//
// Purpose: holds the 2048-channel downselection mask as two banks of
// NUM_WORDS x 32-bit words. The register side always writes the inactive
// (shadow) bank. A commit swaps the banks and streams the newly active bank
// as one NUM_WORDS-beat AXI-stream burst, with tlast on the final word.
// Optionally, the burst start waits for a frame_sync pulse. After each
// completed burst, the popcount of the mask that was sent is published.
//
// Ports:
//   clk                   clock
//   sync_reset            asynchronous, active-high reset
//   cfg_wr_en/addr/data   write a mask word into the shadow bank
//   cfg_commit            request a bank swap and a burst (one cycle)
//   frame_sync            frame-boundary pulse (used when ALIGN_TO_FRAME=1)
//   m_axis_select_*       AXI-stream master carrying the mask words
//   busy                  sequencer is not idle
//   commit_pending        a commit is queued behind the current burst
//   num_selected          popcount of the last fully sent mask
//   num_valid             one-cycle pulse when num_selected updates
//   burst_count           number of completed bursts (wraps at 16 bits)
module downselect_mask_sequencer #(
    parameter int ALIGN_TO_FRAME = 0,
    parameter int NUM_WORDS      = 64
) (
    input  logic        clk,
    input  logic        sync_reset,
    input  logic        cfg_wr_en,
    input  logic [5:0]  cfg_wr_addr,
    input  logic [31:0] cfg_wr_data,
    input  logic        cfg_commit,
    input  logic        frame_sync,
    output logic        m_axis_select_tvalid,
    output logic [31:0] m_axis_select_tdata,
    output logic        m_axis_select_tlast,
    input  logic        m_axis_select_tready,
    output logic        busy,
    output logic        commit_pending,
    output logic [11:0] num_selected,
    output logic        num_valid,
    output logic [15:0] burst_count
);

    localparam int         DEPTH    = 2 * NUM_WORDS;
    localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SYNC,
        S_STREAM,
        S_DONE
    } state_t;

    state_t      state_reg, state_next;
    logic        active_bank_reg, bank_next;
    logic        pending_reg, pending_next;
    logic        tvalid_reg, tvalid_next;
    logic        tlast_reg;
    logic [31:0] tdata_reg;
    logic [5:0]  word_idx_reg;
    logic [11:0] acc_reg;
    logic [11:0] num_selected_reg;
    logic        num_valid_reg;
    logic [15:0] burst_count_reg;

    logic        handshake;
    logic        start_burst;
    logic        load_en;
    logic        done_en;
    logic        rd_bank;
    logic [5:0]  rd_addr;
    logic [6:0]  wr_index;
    logic [6:0]  rd_index;
    logic        rd_fwd;
    logic [31:0] rd_data;
    logic [5:0]  beat_ones;

    // Both banks live in one array; the bank select is the address MSB.
    logic [31:0] bank_mem [0:DEPTH-1];

    function automatic logic [5:0] popcount32(input logic [31:0] w);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, w[i]};
        end
        return n;
    endfunction

    assign handshake = tvalid_reg & m_axis_select_tready;
    assign beat_ones = popcount32(tdata_reg);

    assign wr_index = {~active_bank_reg, cfg_wr_addr};
    assign rd_index = {rd_bank, rd_addr};
    // A write that lands in the same cycle the first word of a freshly
    // swapped bank is fetched must be seen by that fetch.
    assign rd_fwd   = cfg_wr_en && (wr_index == rd_index);
    assign rd_data  = rd_fwd ? cfg_wr_data : bank_mem[rd_index];

    always_ff @(posedge clk) begin
        if (cfg_wr_en) begin
            bank_mem[wr_index] <= cfg_wr_data;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_next   = state_reg;
        bank_next    = active_bank_reg;
        pending_next = pending_reg;
        tvalid_next  = tvalid_reg;
        start_burst  = 1'b0;
        load_en      = 1'b0;
        done_en      = 1'b0;
        rd_bank      = active_bank_reg;
        rd_addr      = word_idx_reg + 6'd1;

        case (state_reg)
            S_IDLE: begin
                if (cfg_commit) begin
                    start_burst = 1'b1;
                end
            end
            S_WAIT_SYNC: begin
                if (cfg_commit) begin
                    pending_next = 1'b1;
                end
                if (frame_sync) begin
                    state_next  = S_STREAM;
                    load_en     = 1'b1;
                    rd_addr     = '0;
                    tvalid_next = 1'b1;
                end
            end
            S_STREAM: begin
                if (cfg_commit) begin
                    pending_next = 1'b1;
                end
                if (handshake) begin
                    if (tlast_reg) begin
                        state_next  = S_DONE;
                        tvalid_next = 1'b0;
                    end else begin
                        load_en = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_en      = 1'b1;
                pending_next = 1'b0;
                // A commit arriving in this very cycle is treated as pending
                // and honoured right away.
                if (pending_reg || cfg_commit) begin
                    start_burst = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (start_burst) begin
            bank_next = ~active_bank_reg;
            if (ALIGN_TO_FRAME != 0) begin
                // A frame_sync coincident with the commit is ignored because
                // the pulse is only looked at once in S_WAIT_SYNC.
                state_next = S_WAIT_SYNC;
            end else begin
                state_next  = S_STREAM;
                load_en     = 1'b1;
                rd_bank     = ~active_bank_reg;
                rd_addr     = '0;
                tvalid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_reg        <= S_IDLE;
            active_bank_reg  <= 1'b0;
            pending_reg      <= 1'b0;
            tvalid_reg       <= 1'b0;
            tlast_reg        <= 1'b0;
            tdata_reg        <= '0;
            word_idx_reg     <= '0;
            acc_reg          <= '0;
            num_selected_reg <= '0;
            num_valid_reg    <= 1'b0;
            burst_count_reg  <= '0;
        end else begin
            state_reg       <= state_next;
            active_bank_reg <= bank_next;
            pending_reg     <= pending_next;
            tvalid_reg      <= tvalid_next;

            if (load_en) begin
                tdata_reg    <= rd_data;
                tlast_reg    <= (rd_addr == LAST_IDX);
                word_idx_reg <= rd_addr;
            end else begin
                if (!tvalid_next) begin
                    tlast_reg <= 1'b0;
                end
                if (start_burst) begin
                    word_idx_reg <= '0;
                end
            end

            // 2048 ones is the maximum and still fits the 12-bit accumulator.
            if (done_en) begin
                num_selected_reg <= acc_reg;
                acc_reg          <= '0;
                burst_count_reg  <= burst_count_reg + 16'd1;
            end else if (handshake) begin
                acc_reg <= acc_reg + {6'd0, beat_ones};
            end

            num_valid_reg <= done_en;
        end
    end

    assign m_axis_select_tvalid = tvalid_reg;
    assign m_axis_select_tdata  = tdata_reg;
    assign m_axis_select_tlast  = tlast_reg;
    assign busy                 = (state_reg != S_IDLE);
    assign commit_pending       = pending_reg;
    assign num_selected         = num_selected_reg;
    assign num_valid            = num_valid_reg;
    assign burst_count          = burst_count_reg;

endmodule

// File: tb/tb_downselect_mask_sequencer.sv
// tb_downselect_mask_sequencer
//
// Purpose: self-checking bench for downselect_mask_sequencer. Stimulus is
// directed scenarios followed by a randomized phase. A bank/commit model
// pushes the expected words and popcounts into queues. A negedge monitor
// pops and compares them whenever the DUT hands over a beat or a
// num_valid pulse. A second instance with ALIGN_TO_FRAME=1 covers
// frame alignment.
//
// Ports: none (top-level bench).
module tb_downselect_mask_sequencer;

    logic        clk = 1'b0;
    logic        sync_reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        commit = 1'b0;
    logic        commit1 = 1'b0;
    logic        fsync = 1'b0;
    logic        tready = 1'b1;
    logic        tready1 = 1'b1;

    logic        tvalid, tlast, busy, pending, num_valid;
    logic [31:0] tdata;
    logic [11:0] num_selected;
    logic [15:0] burst_count;

    logic        tvalid1, tlast1, busy1, pending1, num_valid1;
    logic [31:0] tdata1;
    logic [11:0] num_selected1;
    logic [15:0] burst_count1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    downselect_mask_sequencer #(.ALIGN_TO_FRAME(0), .NUM_WORDS(64)) dut (
        .clk(clk), .sync_reset(sync_reset),
        .cfg_wr_en(wr_en), .cfg_wr_addr(wr_addr), .cfg_wr_data(wr_data),
        .cfg_commit(commit), .frame_sync(fsync),
        .m_axis_select_tvalid(tvalid), .m_axis_select_tdata(tdata),
        .m_axis_select_tlast(tlast), .m_axis_select_tready(tready),
        .busy(busy), .commit_pending(pending),
        .num_selected(num_selected), .num_valid(num_valid),
        .burst_count(burst_count)
    );

    downselect_mask_sequencer #(.ALIGN_TO_FRAME(1), .NUM_WORDS(64)) dut_align (
        .clk(clk), .sync_reset(sync_reset),
        .cfg_wr_en(wr_en), .cfg_wr_addr(wr_addr), .cfg_wr_data(wr_data),
        .cfg_commit(commit1), .frame_sync(fsync),
        .m_axis_select_tvalid(tvalid1), .m_axis_select_tdata(tdata1),
        .m_axis_select_tlast(tlast1), .m_axis_select_tready(tready1),
        .busy(busy1), .commit_pending(pending1),
        .num_selected(num_selected1), .num_valid(num_valid1),
        .burst_count(burst_count1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (ALIGN_TO_FRAME=0 instance) ----------
    // Two banks; writes go to the one not being sent. A commit either starts
    // a burst at once or is remembered until the running burst has finished.
    logic [31:0] m_bank [2][64];
    int          m_act = 0;
    bit          m_busy = 0, m_pending = 0, m_valid = 0, m_done = 0, m_done_now = 0;
    int          m_beats = 0;
    int          m_bursts = 0;
    logic [31:0] exp_q[$];
    int          cnt_q[$];

    task automatic start_burst();
        int pc;
        pc = 0;
        m_act = 1 - m_act;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(m_bank[m_act][i]);
            pc += $countones(m_bank[m_act][i]);
        end
        cnt_q.push_back(pc);
        m_busy  = 1;
        m_valid = 1;
        m_beats = 0;
    endtask

    always @(posedge clk) begin
        if (sync_reset) begin
            m_act = 0; m_busy = 0; m_pending = 0; m_valid = 0; m_done = 0;
            m_beats = 0; m_bursts = 0;
            exp_q.delete();
            cnt_q.delete();
        end else begin
            m_done_now = 0;
            if (m_valid && tready) begin
                m_beats++;
                if (m_beats == 64) begin
                    m_valid    = 0;
                    m_done_now = 1;
                end
            end
            if (wr_en) m_bank[1 - m_act][wr_addr] = wr_data;
            if (m_done) begin
                m_bursts = (m_bursts + 1) % 65536;
                if (m_pending || commit) start_burst();
                else m_busy = 0;
                m_pending = 0;
            end else if (commit) begin
                if (m_busy) m_pending = 1;
                else start_burst();
            end
            m_done = m_done_now;
        end
    end

    // ---------------- monitor ----------------------------------------------
    int          mon_beat = 0;
    bit          hold_v = 0;
    logic [31:0] hold_d = '0;

    always @(negedge clk) begin
        if (sync_reset) begin
            mon_beat = 0;
            hold_v   = 0;
        end else begin
            chk("tvalid", {31'd0, tvalid}, {31'd0, m_valid});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("commit_pending", {31'd0, pending}, {31'd0, m_pending});
            if (tvalid) begin
                chk("tlast", {31'd0, tlast}, (mon_beat == 63) ? 32'd1 : 32'd0);
                if (hold_v) chk("stall_data", tdata, hold_d);
                if (tready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL tdata: unexpected beat 0x%0h, expected none", tdata);
                    end else begin
                        chk("tdata", tdata, exp_q.pop_front());
                    end
                    mon_beat = (mon_beat + 1) % 64;
                    hold_v   = 0;
                end else begin
                    hold_v = 1;
                    hold_d = tdata;
                end
            end else begin
                hold_v = 0;
            end
            if (num_valid) begin
                if (cnt_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL num_valid: unexpected pulse, num_selected=%0d, expected none", num_selected);
                end else begin
                    chk("num_selected", {20'd0, num_selected}, cnt_q.pop_front());
                end
                chk("burst_count", {16'd0, burst_count}, m_bursts);
                $display("burst %0d complete: num_selected=%0d", burst_count, num_selected);
            end
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en = 1; wr_addr = 6'(a); wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic pulse_commit();
        commit = 1;
        tick();
        commit = 0;
    endtask

    // mode: 0 = tready high, 1 = toggle every cycle, 2 = random
    task automatic wait_idle(input int mode, input int budget);
        int n;
        n = 0;
        while ((m_busy || m_pending) && n < budget) begin
            case (mode)
                0: tready = 1;
                1: tready = ~tready;
                default: tready = ($urandom_range(3) != 0);
            endcase
            tick();
            n++;
        end
        tready = 1;
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
        end
        tick();
        tick();
    endtask

    initial begin
        int cnt_hi, beats, lastpos;

        // Reset values
        repeat (3) tick();
        sync_reset = 0;
        chk("rst_tvalid", {31'd0, tvalid}, 0);
        chk("rst_tlast", {31'd0, tlast}, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_pending", {31'd0, pending}, 0);
        chk("rst_num_selected", {20'd0, num_selected}, 0);
        chk("rst_num_valid", {31'd0, num_valid}, 0);
        chk("rst_burst_count", {16'd0, burst_count}, 0);

        // All words 0x1, immediate start
        for (int i = 0; i < 64; i++) write_word(i, 32'h0000_0001);
        pulse_commit();
        chk("first_beat_latency", {31'd0, tvalid}, 1);
        wait_idle(0, 500);
        chk("t1_num_selected", {20'd0, num_selected}, 64);
        chk("t1_burst_count", {16'd0, burst_count}, 1);

        // All ones with tready toggling
        for (int i = 0; i < 64; i++) write_word(i, 32'hFFFF_FFFF);
        pulse_commit();
        wait_idle(1, 500);
        chk("t2_num_selected", {20'd0, num_selected}, 2048);

        // Writes and double commit during a burst
        pulse_commit();
        repeat (3) tick();
        write_word(5, 32'hA5A5_A5A5);
        pulse_commit();
        chk("t3_pending_set", {31'd0, pending}, 1);
        repeat (5) tick();
        pulse_commit();
        wait_idle(0, 500);
        chk("t3_burst_count", {16'd0, burst_count}, 4);
        chk("t3_num_selected", {20'd0, num_selected}, 2048 - 32 + 16);

        // Same-cycle write and commit
        wr_en = 1; wr_addr = 6'd63; wr_data = 32'h8000_0000; commit = 1;
        tick();
        wr_en = 0; commit = 0;
        wait_idle(0, 500);

        // Reset in the middle of a burst
        pulse_commit();
        for (int n = 0; n < 200 && mon_beat != 20; n++) tick();
        chk("t5_reached_beat20", mon_beat, 20);
        @(negedge clk);
        #2;
        sync_reset = 1;
        #1;
        chk("t5_rst_tvalid", {31'd0, tvalid}, 0);
        chk("t5_rst_busy", {31'd0, busy}, 0);
        tick();
        tick();
        sync_reset = 0;
        chk("t5_num_selected_cleared", {20'd0, num_selected}, 0);
        pulse_commit();
        wait_idle(0, 500);
        chk("t5_burst_count", {16'd0, burst_count}, 1);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            wr_en   = $urandom_range(1);
            wr_addr = 6'($urandom_range(63));
            wr_data = $urandom;
            commit  = ($urandom_range(59) == 0);
            tready  = ($urandom_range(3) != 0);
            tick();
        end
        wr_en = 0; commit = 0;
        wait_idle(2, 2000);

        // Frame alignment on the ALIGN_TO_FRAME=1 instance
        sync_reset = 1;
        tick();
        tick();
        sync_reset = 0;
        write_word(0, 32'hCAFE_0001);
        repeat (8) tick();
        commit1 = 1; fsync = 1;
        tick();
        commit1 = 0; fsync = 0;
        cnt_hi = 0;
        for (int c = 11; c < 40; c++) begin
            if (tvalid1) cnt_hi++;
            tick();
        end
        chk("align_held_off", cnt_hi, 0);
        chk("align_busy", {31'd0, busy1}, 1);
        fsync = 1;
        tick();
        fsync = 0;
        chk("align_first_beat", {31'd0, tvalid1}, 1);
        chk("align_first_data", tdata1, 32'hCAFE_0001);
        beats = 0;
        lastpos = -1;
        while (tvalid1 && beats < 100) begin
            if (tlast1) lastpos = beats;
            beats++;
            tick();
        end
        chk("align_beats", beats, 64);
        chk("align_tlast_pos", lastpos, 63);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
